id_decode_stage: RTL and testbench

//  MIPS decode stage sitting directly upstream of the register file (RF).

---
 rtl/mips_pkg.sv | 55 +++++
 rtl/mips_ctrl_decode.sv | 66 ++++++
 rtl/id_decode_stage.sv | 155 +++++++++++++++
 tb/tb_id_decode_stage.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// ============================================================================
// mips_pkg : opcode/funct encodings, ALU op enum and decoded-control bundle
// Rev 1.0
// ============================================================================
`default_nettype none

package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_NOR = 3'd4,
        ALU_SLT = 3'd5
    } alu_op_e;

    typedef enum logic [1:0] {
        DEST_NONE = 2'd0,
        DEST_RD   = 2'd1,
        DEST_RT   = 2'd2
    } dest_sel_e;

    typedef struct packed {
        logic      legal;
        alu_op_e   alu_op;
        logic      alu_src;
        logic      reg_write;
        logic      mem_read;
        logic      mem_write;
        logic      branch;
        logic      uses_rt;
        logic      zero_ext;
        dest_sel_e dest_sel;
    } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/mips_ctrl_decode.sv
// ============================================================================
// mips_ctrl_decode : combinational opcode/funct -> control bundle
// Rev 1.0
// ============================================================================
`default_nettype none

module mips_ctrl_decode
    import mips_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o          = '0;
        ctrl_o.alu_op   = ALU_ADD;
        ctrl_o.dest_sel = DEST_NONE;
        // Operand-use is opcode-only so the hazard check never depends on legality
        ctrl_o.uses_rt  = (opcode_i == OP_RTYPE) | (opcode_i == OP_SW) | (opcode_i == OP_BEQ);
        case (opcode_i)
            OP_RTYPE: begin
                ctrl_o.legal     = 1'b1;
                ctrl_o.reg_write = 1'b1;
                ctrl_o.dest_sel  = DEST_RD;
                case (funct_i)
                    FN_ADD:  ctrl_o.alu_op = ALU_ADD;
                    FN_SUB:  ctrl_o.alu_op = ALU_SUB;
                    FN_AND:  ctrl_o.alu_op = ALU_AND;
                    FN_OR:   ctrl_o.alu_op = ALU_OR;
                    FN_NOR:  ctrl_o.alu_op = ALU_NOR;
                    FN_SLT:  ctrl_o.alu_op = ALU_SLT;
                    default: ctrl_o.legal  = 1'b0;
                endcase
            end
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LW: begin
                ctrl_o.legal     = 1'b1;
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.reg_write = 1'b1;
                ctrl_o.dest_sel  = DEST_RT;
                ctrl_o.mem_read  = (opcode_i == OP_LW);
                ctrl_o.zero_ext  = (opcode_i == OP_ANDI) | (opcode_i == OP_ORI);
                case (opcode_i)
                    OP_SLTI: ctrl_o.alu_op = ALU_SLT;
                    OP_ANDI: ctrl_o.alu_op = ALU_AND;
                    OP_ORI:  ctrl_o.alu_op = ALU_OR;
                    default: ctrl_o.alu_op = ALU_ADD;
                endcase
            end
            OP_SW: begin
                ctrl_o.legal     = 1'b1;
                ctrl_o.alu_src   = 1'b1;
                ctrl_o.mem_write = 1'b1;
            end
            OP_BEQ: begin
                ctrl_o.legal  = 1'b1;
                ctrl_o.alu_op = ALU_SUB;
                ctrl_o.branch = 1'b1;
            end
            default: ctrl_o.legal = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/id_decode_stage.sv
// ============================================================================
// id_decode_stage : MIPS decode, load-use hazard detect, ID/EX register
// Rev 1.0
// ============================================================================
`default_nettype none

module id_decode_stage
    import mips_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_instr,
    input  logic [DW-1:0] in_pc4,
    input  logic          flush,
    output logic [AW-1:0] RS_Address,
    output logic [AW-1:0] RT_Address,
    input  logic [DW-1:0] RSdata,
    input  logic [DW-1:0] RTdata,
    output logic          stall,
    output logic          ex_valid,
    output logic [DW-1:0] ex_rs_data,
    output logic [DW-1:0] ex_rt_data,
    output logic [DW-1:0] ex_imm,
    output logic [DW-1:0] ex_pc4,
    output logic [AW-1:0] ex_dest,
    output logic [2:0]    ex_alu_op,
    output logic          ex_alu_src,
    output logic          ex_reg_write,
    output logic          ex_mem_read,
    output logic          ex_mem_write,
    output logic          ex_branch,
    output logic          ex_illegal
);

    ctrl_t         w_ctrl;
    logic [AW-1:0] w_rd;
    logic [AW-1:0] w_dest;
    logic [DW-1:0] w_imm;
    logic          w_hazard;
    logic          w_load;
    logic          w_issue;

    logic          valid_q, valid_d;
    logic [DW-1:0] rs_data_q, rt_data_q, imm_q, pc4_q;
    logic [AW-1:0] dest_q, dest_d;
    alu_op_e       alu_op_q, alu_op_d;
    logic          alu_src_q, alu_src_d;
    logic          reg_write_q, reg_write_d;
    logic          mem_read_q, mem_read_d;
    logic          mem_write_q, mem_write_d;
    logic          branch_q, branch_d;
    logic          illegal_q, illegal_d;

    mips_ctrl_decode u_ctrl_decode (
        .opcode_i (in_instr[31:26]),
        .funct_i  (in_instr[5:0]),
        .ctrl_o   (w_ctrl)
    );

    assign RS_Address = in_instr[25:21];
    assign RT_Address = in_instr[20:16];
    assign w_rd       = in_instr[15:11];

    assign w_imm = w_ctrl.zero_ext ? {{(DW-16){1'b0}}, in_instr[15:0]}
                                   : {{(DW-16){in_instr[15]}}, in_instr[15:0]};

    always_comb begin
        case (w_ctrl.dest_sel)
            DEST_RD: w_dest = w_rd;
            DEST_RT: w_dest = RT_Address;
            default: w_dest = '0;
        endcase
    end

    // Loads writing $0 never create a hazard since $0 is never written
    assign w_hazard = valid_q & mem_read_q & (dest_q != '0) &
                      ((dest_q == RS_Address) | (w_ctrl.uses_rt & (dest_q == RT_Address)));
    assign stall    = in_valid & w_hazard & ~flush;
    assign w_load   = in_valid & ~flush & ~stall;
    assign w_issue  = w_load & w_ctrl.legal;

    always_comb begin
        valid_d     = w_issue;
        illegal_d   = w_load & ~w_ctrl.legal;
        dest_d      = '0;
        alu_op_d    = ALU_ADD;
        alu_src_d   = 1'b0;
        reg_write_d = 1'b0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        branch_d    = 1'b0;
        if (w_issue) begin
            dest_d      = w_dest;
            alu_op_d    = w_ctrl.alu_op;
            alu_src_d   = w_ctrl.alu_src;
            reg_write_d = w_ctrl.reg_write & (w_dest != '0);
            mem_read_d  = w_ctrl.mem_read;
            mem_write_d = w_ctrl.mem_write;
            branch_d    = w_ctrl.branch;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= 1'b0;
            rs_data_q   <= '0;
            rt_data_q   <= '0;
            imm_q       <= '0;
            pc4_q       <= '0;
            dest_q      <= '0;
            alu_op_q    <= ALU_ADD;
            alu_src_q   <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            branch_q    <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            rs_data_q   <= RSdata;
            rt_data_q   <= RTdata;
            imm_q       <= w_imm;
            pc4_q       <= in_pc4;
            dest_q      <= dest_d;
            alu_op_q    <= alu_op_d;
            alu_src_q   <= alu_src_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            branch_q    <= branch_d;
            illegal_q   <= illegal_d;
        end
    end

    assign ex_valid     = valid_q;
    assign ex_rs_data   = rs_data_q;
    assign ex_rt_data   = rt_data_q;
    assign ex_imm       = imm_q;
    assign ex_pc4       = pc4_q;
    assign ex_dest      = dest_q;
    assign ex_alu_op    = alu_op_q;
    assign ex_alu_src   = alu_src_q;
    assign ex_reg_write = reg_write_q;
    assign ex_mem_read  = mem_read_q;
    assign ex_mem_write = mem_write_q;
    assign ex_branch    = branch_q;
    assign ex_illegal   = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_id_decode_stage.sv
// ============================================================================
// tb_id_decode_stage : vector table + scoreboard bench for id_decode_stage
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_id_decode_stage;
    import mips_pkg::*;

    typedef struct {
        logic        v;
        logic [31:0] rs, rt, imm, pc4;
        logic [4:0]  dest;
        logic [2:0]  op;
        logic        src, rw, mr, mw, br, ill;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic        valid, flush, stall;
        exp_t        e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc4 = '0;
    logic        flush = 1'b0;
    logic [4:0]  RS_Address, RT_Address;
    logic [31:0] RSdata, RTdata;
    logic        stall, ex_valid;
    logic [31:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc4;
    logic [4:0]  ex_dest;
    logic [2:0]  ex_alu_op;
    logic        ex_alu_src, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal;

    logic [31:0] rf [32];
    exp_t        sb [$];
    vec_t        vt [32];
    int          n_vec = 0;
    int          n_pass = 0;
    int          n_total = 0;
    int          pc_n = 0;

    always #5 clk = ~clk;

    assign RSdata = rf[RS_Address];
    assign RTdata = rf[RT_Address];

    id_decode_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_pc4(in_pc4),
        .flush(flush), .RS_Address(RS_Address), .RT_Address(RT_Address),
        .RSdata(RSdata), .RTdata(RTdata), .stall(stall), .ex_valid(ex_valid),
        .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_pc4(ex_pc4),
        .ex_dest(ex_dest), .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_branch(ex_branch), .ex_illegal(ex_illegal)
    );

    function automatic exp_t ex(logic [31:0] rsd, logic [31:0] rtd, logic [31:0] imm,
                                logic [4:0] dest, logic [2:0] op,
                                logic src, logic rw, logic mr, logic mw, logic br);
        exp_t e;
        e.v = 1'b1; e.rs = rsd; e.rt = rtd; e.imm = imm; e.pc4 = '0; e.dest = dest;
        e.op = op; e.src = src; e.rw = rw; e.mr = mr; e.mw = mw; e.br = br; e.ill = 1'b0;
        return e;
    endfunction

    function automatic exp_t bub(logic ill);
        exp_t e;
        e = ex('0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        e.v = 1'b0; e.ill = ill;
        return e;
    endfunction

    task automatic add_vec(logic [31:0] instr, logic valid, logic fl, logic st, exp_t e);
        vt[n_vec].instr = instr; vt[n_vec].valid = valid; vt[n_vec].flush = fl;
        vt[n_vec].stall = st; vt[n_vec].e = e;
        n_vec++;
    endtask

    task automatic chk(string nm, logic [127:0] got, logic [127:0] want);
        n_total++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, got, want);
    endtask

    task automatic cmp_ex(string nm, exp_t e);
        chk({nm, " ctrl"},
            {118'd0, ex_valid, ex_alu_op, ex_alu_src, ex_reg_write, ex_mem_read,
             ex_mem_write, ex_branch, ex_illegal},
            {118'd0, e.v, e.op, e.src, e.rw, e.mr, e.mw, e.br, e.ill});
        if (e.v) begin
            chk({nm, " dest"}, {123'd0, ex_dest}, {123'd0, e.dest});
            chk({nm, " data"}, {ex_rs_data, ex_rt_data, ex_imm, ex_pc4},
                {e.rs, e.rt, e.imm, e.pc4});
        end
    endtask

    task automatic step(string nm, vec_t v);
        exp_t e;
        @(negedge clk);
        in_instr = v.instr; in_valid = v.valid; flush = v.flush;
        in_pc4 = 32'h400 + 32'(pc_n * 4); pc_n++;
        e = v.e; e.pc4 = in_pc4;
        #1;
        chk({nm, " stall"}, {127'd0, stall}, {127'd0, v.stall});
        sb.push_back(e);
        @(posedge clk); #1;
        cmp_ex(nm, sb.pop_front());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        vec_t v;
        for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + 32'(i * 7);
        rf[0] = 32'd0; rf[1] = 32'd11; rf[2] = 32'd370;

        // Decode table
        add_vec(32'h00221820, 1, 0, 0, ex(rf[1], rf[2], 32'h00001820, 5'd3,  ALU_ADD, 0, 1, 0, 0, 0));
        add_vec(32'h00223822, 1, 0, 0, ex(rf[1], rf[2], 32'h00003822, 5'd7,  ALU_SUB, 0, 1, 0, 0, 0));
        add_vec(32'h00224024, 1, 0, 0, ex(rf[1], rf[2], 32'h00004024, 5'd8,  ALU_AND, 0, 1, 0, 0, 0));
        add_vec(32'h00224825, 1, 0, 0, ex(rf[1], rf[2], 32'h00004825, 5'd9,  ALU_OR,  0, 1, 0, 0, 0));
        add_vec(32'h00225027, 1, 0, 0, ex(rf[1], rf[2], 32'h00005027, 5'd10, ALU_NOR, 0, 1, 0, 0, 0));
        add_vec(32'h0022582A, 1, 0, 0, ex(rf[1], rf[2], 32'h0000582A, 5'd11, ALU_SLT, 0, 1, 0, 0, 0));
        add_vec(32'h3024FFFF, 1, 0, 0, ex(rf[1], rf[4], 32'h0000FFFF, 5'd4,  ALU_AND, 1, 1, 0, 0, 0));
        add_vec(32'h2024FFFF, 1, 0, 0, ex(rf[1], rf[4], 32'hFFFFFFFF, 5'd4,  ALU_ADD, 1, 1, 0, 0, 0));
        add_vec(32'h344C8000, 1, 0, 0, ex(rf[2], rf[12], 32'h00008000, 5'd12, ALU_OR, 1, 1, 0, 0, 0));
        add_vec(32'h282D8001, 1, 0, 0, ex(rf[1], rf[13], 32'hFFFF8001, 5'd13, ALU_SLT, 1, 1, 0, 0, 0));
        add_vec(32'hAC220004, 1, 0, 0, ex(rf[1], rf[2], 32'h00000004, 5'd0,  ALU_ADD, 1, 0, 0, 1, 0));
        add_vec(32'h10220008, 1, 0, 0, ex(rf[1], rf[2], 32'h00000008, 5'd0,  ALU_SUB, 0, 0, 0, 0, 1));
        add_vec(32'hFC000000, 1, 0, 0, bub(1'b1));
        add_vec(32'h00221821, 1, 0, 0, bub(1'b1));
        add_vec(32'h20200005, 1, 0, 0, ex(rf[1], rf[0], 32'h00000005, 5'd0,  ALU_ADD, 1, 0, 0, 0, 0));
        add_vec(32'h00221820, 0, 0, 0, bub(1'b0));
        add_vec(32'h00221820, 1, 1, 0, bub(1'b0));
        // Load-use: stall one cycle, then re-decode
        add_vec(32'h8C250000, 1, 0, 0, ex(rf[1], rf[5], 32'h0, 5'd5, ALU_ADD, 1, 1, 1, 0, 0));
        add_vec(32'h00A23020, 1, 0, 1, bub(1'b0));
        add_vec(32'h00A23020, 1, 0, 0, ex(rf[5], rf[2], 32'h00003020, 5'd6, ALU_ADD, 0, 1, 0, 0, 0));
        // Flush beats stall
        add_vec(32'h8C250000, 1, 0, 0, ex(rf[1], rf[5], 32'h0, 5'd5, ALU_ADD, 1, 1, 1, 0, 0));
        add_vec(32'h00A23020, 1, 1, 0, bub(1'b0));
        // Load to $0 never stalls
        add_vec(32'h8C200000, 1, 0, 0, ex(rf[1], rf[0], 32'h0, 5'd0, ALU_ADD, 1, 0, 1, 0, 0));
        add_vec(32'h00023020, 1, 0, 0, ex(rf[0], rf[2], 32'h00003020, 5'd6, ALU_ADD, 0, 1, 0, 0, 0));
        // I-type rt is a destination, not a source: no stall
        add_vec(32'h8C250000, 1, 0, 0, ex(rf[1], rf[5], 32'h0, 5'd5, ALU_ADD, 1, 1, 1, 0, 0));
        add_vec(32'h20250001, 1, 0, 0, ex(rf[1], rf[5], 32'h00000001, 5'd5, ALU_ADD, 1, 1, 0, 0, 0));
        // Store data on rt does stall
        add_vec(32'h8C250000, 1, 0, 0, ex(rf[1], rf[5], 32'h0, 5'd5, ALU_ADD, 1, 1, 1, 0, 0));
        add_vec(32'hAC250004, 1, 0, 1, bub(1'b0));
        add_vec(32'hAC250004, 1, 0, 0, ex(rf[1], rf[5], 32'h00000004, 5'd0, ALU_ADD, 1, 0, 0, 1, 0));
        // Hazard pattern with in_valid low: no stall
        add_vec(32'h8C250000, 1, 0, 0, ex(rf[1], rf[5], 32'h0, 5'd5, ALU_ADD, 1, 1, 1, 0, 0));
        add_vec(32'h00A23020, 0, 0, 0, bub(1'b0));

        // Reset state
        #3;
        chk("reset outs", {ex_valid, ex_rs_data, ex_rt_data, ex_imm, ex_pc4[31:1]},
            {1'b0, 127'd0});
        chk("reset ctrl", {108'd0, ex_pc4[0], ex_dest, ex_alu_op, ex_alu_src, ex_reg_write,
                           ex_mem_read, ex_mem_write, ex_branch, ex_illegal, stall}, 128'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < n_vec; i++) step($sformatf("vec%0d", i), vt[i]);

        // Asynchronous reset in mid-cycle while a load-use hazard is pending
        v.instr = 32'h8C250000; v.valid = 1; v.flush = 0; v.stall = 0;
        v.e = ex(rf[1], rf[5], 32'h0, 5'd5, ALU_ADD, 1, 1, 1, 0, 0);
        step("pre-rst lw", v);
        in_instr = 32'h00A23020; in_valid = 1'b1; in_pc4 = 32'h0000_0F00;
        #1;
        chk("pre-rst stall", {127'd0, stall}, 128'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("mid-rst clear", {ex_valid, ex_rs_data, ex_rt_data, ex_imm, ex_pc4[31:1]},
            {1'b0, 127'd0});
        chk("mid-rst ctrl", {108'd0, ex_pc4[0], ex_dest, ex_alu_op, ex_alu_src, ex_reg_write,
                             ex_mem_read, ex_mem_write, ex_branch, ex_illegal, stall}, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        e = ex(rf[5], rf[2], 32'h00003020, 5'd6, ALU_ADD, 0, 1, 0, 0, 0);
        e.pc4 = 32'h0000_0F00;
        sb.push_back(e);
        @(posedge clk); #1;
        cmp_ex("post-rst add", sb.pop_front());
        chk("sb empty", {96'd0, 32'(sb.size())}, 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
